// File: rtl/spin_step_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : spin_step_gen_if
// Brief   : Button input and Run/Step/AtSpeed outputs of the spinner step path.
// Rev     : 1.0  initial release
// ============================================================================
interface spin_step_gen_if;
    logic Start;
    logic Run;
    logic Step;
    logic AtSpeed;

    modport master (output Start, input Run, input Step, input AtSpeed);
    modport slave  (input Start, output Run, output Step, output AtSpeed);
endinterface
`default_nettype wire

// File: rtl/spin_step_gen.sv
`default_nettype none
// ============================================================================
// Module  : spin_step_gen
// Brief   : Debounced start/stop toggle driving a ramped step-pulse generator.
// Rev     : 1.0  initial release
// ============================================================================
module spin_step_gen #(
    parameter int DEB_CYCLES = 16,
    parameter int DIV_W      = 16,
    parameter int SLOW_DIV   = 50000,
    parameter int FAST_DIV   = 12500,
    parameter int RAMP_STEP  = 2500
) (
    input  wire logic       Clk,
    input  wire logic       Reset,
    spin_step_gen_if.slave  bus
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_DEB    = CNT_W'(DEB_CYCLES);
    localparam logic [DIV_W-1:0] c_SLOW   = DIV_W'(SLOW_DIV);
    localparam logic [DIV_W-1:0] c_FAST   = DIV_W'(FAST_DIV);
    localparam logic [DIV_W-1:0] c_RAMP   = DIV_W'(RAMP_STEP);
    localparam logic [DIV_W:0]   c_SLOW_X = (DIV_W+1)'(SLOW_DIV);
    localparam logic [DIV_W:0]   c_FAST_X = (DIV_W+1)'(FAST_DIV);
    localparam logic [DIV_W:0]   c_RAMP_X = (DIV_W+1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser, debounce, press detection
    // ------------------------------------------------------------------
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             press_q;
    logic [CNT_W-1:0] deb_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            press_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= bus.Start;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == c_DEB) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
                press_q   <= sync2_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider and period arithmetic
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] period_q;
    logic             run_q;
    logic             step_q;
    logic             at_speed_q;

    logic             wrap;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W:0]   per_x;
    logic [DIV_W:0]   margin_x;
    logic [DIV_W:0]   dec_x;
    logic [DIV_W-1:0] per_acc_d;
    logic [DIV_W-1:0] per_dec_d;
    logic             dec_done;

    // Widened by one bit so neither the margin nor the sum can wrap.
    always_comb begin
        wrap      = (state_q != ST_IDLE) && (div_q == (period_q - DIV_W'(1)));
        div_d     = wrap ? '0 : (div_q + DIV_W'(1));
        per_x     = {1'b0, period_q};
        margin_x  = per_x - c_FAST_X;
        dec_x     = per_x + c_RAMP_X;
        per_acc_d = (margin_x >= c_RAMP_X) ? (period_q - c_RAMP) : c_FAST;
        dec_done  = (dec_x >= c_SLOW_X);
        per_dec_d = dec_done ? c_SLOW : dec_x[DIV_W-1:0];
    end

    // ------------------------------------------------------------------
    // Speed-ramp state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            period_q   <= c_SLOW;
            run_q      <= 1'b0;
            step_q     <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            step_q <= wrap;
            case (state_q)
                ST_IDLE: begin
                    div_q <= '0;
                    if (press_q) begin
                        state_q    <= ST_ACCEL;
                        period_q   <= c_SLOW;
                        run_q      <= 1'b1;
                        at_speed_q <= 1'b0;
                    end
                end
                ST_ACCEL: begin
                    div_q <= div_d;
                    if (wrap) begin
                        period_q <= per_acc_d;
                        if (press_q) begin
                            state_q <= ST_DECEL;
                        end else if (per_acc_d == c_FAST) begin
                            state_q    <= ST_CRUISE;
                            at_speed_q <= 1'b1;
                        end
                    end else if (press_q) begin
                        state_q <= ST_DECEL;
                    end
                end
                ST_CRUISE: begin
                    div_q <= div_d;
                    if (press_q) begin
                        state_q    <= ST_DECEL;
                        at_speed_q <= 1'b0;
                    end
                end
                ST_DECEL: begin
                    div_q <= div_d;
                    // Reaching the slow end stops the spinner even if a press coincides.
                    if (wrap && dec_done) begin
                        state_q    <= ST_IDLE;
                        period_q   <= c_SLOW;
                        run_q      <= 1'b0;
                        at_speed_q <= 1'b0;
                    end else begin
                        if (wrap) begin
                            period_q <= per_dec_d;
                        end
                        if (press_q) begin
                            state_q <= ST_ACCEL;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    div_q      <= '0;
                    period_q   <= c_SLOW;
                    run_q      <= 1'b0;
                    at_speed_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Run     = run_q;
    assign bus.Step    = step_q;
    assign bus.AtSpeed = at_speed_q;

endmodule
`default_nettype wire

// File: tb/tb_spin_step_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_spin_step_gen
// Brief   : Random and directed button stimulus against a timestamp-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spin_step_gen;

    localparam int DEB  = 4;
    localparam int SLOW = 20;
    localparam int FAST = 8;
    localparam int RAMP = 4;

    localparam int M_STOP = 0;
    localparam int M_ACC  = 1;
    localparam int M_CRU  = 2;
    localparam int M_DEC  = 3;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    spin_step_gen_if bus();

    spin_step_gen #(
        .DEB_CYCLES (DEB),
        .DIV_W      (16),
        .SLOW_DIV   (SLOW),
        .FAST_DIV   (FAST),
        .RAMP_STEP  (RAMP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: spinner timing kept as absolute cycle stamps.
    int cyc      = 0;
    int m_mode   = M_STOP;
    int m_period = SLOW;
    int m_next   = 0;
    int m_run    = 0;
    bit m_s1     = 1'b0;
    bit m_s2     = 1'b0;
    bit m_level  = 1'b0;
    bit m_press  = 1'b0;
    bit p_now    = 1'b0;
    bit stopped  = 1'b0;
    bit e_run    = 1'b0;
    bit e_step   = 1'b0;
    bit e_at     = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_mode = M_STOP; m_period = SLOW; m_next = 0; m_run = 0;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0;
            e_run = 0; e_step = 0; e_at = 0;
        end else begin
            cyc++;
            p_now   = m_press;
            stopped = 0;
            e_step  = 0;
            if (m_mode == M_STOP) begin
                if (p_now) begin
                    m_mode   = M_ACC;
                    m_period = SLOW;
                    m_next   = cyc + SLOW;
                end
            end else begin
                if (cyc == m_next) begin
                    e_step = 1;
                    if (m_mode == M_ACC) begin
                        m_period = (m_period - RAMP > FAST) ? m_period - RAMP : FAST;
                        if (m_period == FAST) m_mode = M_CRU;
                    end else if (m_mode == M_DEC) begin
                        if (m_period + RAMP >= SLOW) begin
                            m_period = SLOW;
                            m_mode   = M_STOP;
                            stopped  = 1;
                        end else begin
                            m_period = m_period + RAMP;
                        end
                    end
                    m_next = cyc + m_period;
                end
                if (p_now && !stopped) m_mode = (m_mode == M_DEC) ? M_ACC : M_DEC;
            end
            // Debounce: level flips after DEB+1 consecutive differing synced samples.
            m_press = 0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = m_s2;
                    m_run   = 0;
                    m_press = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_s2  = m_s1;
            m_s1  = bus.Start;
            e_run = (m_mode != M_STOP);
            e_at  = (m_mode == M_CRU);
        end
    end

    always @(negedge Clk) begin
        chk("run_step_atspeed", {29'd0, bus.Run, bus.Step, bus.AtSpeed}, {29'd0, e_run, e_step, e_at});
    end

    task automatic drive(input bit v, input int n);
        #2 bus.Start = v;
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        int k;
        bus.Start = 1'b0;
        Reset     = 1'b1;
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b0;

        repeat (200) @(negedge Clk);
        drive(1, 120);
        drive(0, 20);
        drive(1, 30);
        drive(0, 80);

        for (int i = 0; i < 15; i++) drive(i[0] ? 1'b0 : 1'b1, 2);
        drive(1, 60);
        drive(0, 20);
        repeat (3) begin
            drive(1, 3);
            drive(0, 15);
        end

        repeat (120) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60));
        end

        drive(0, 12);
        if (m_mode == M_ACC || m_mode == M_CRU) drive(1, 10);
        drive(0, 100);
        chk("stopped_before_reset_test", m_mode, M_STOP);

        #2 bus.Start = 1'b1;
        k = 0;
        while (!e_at && k < 150) begin
            @(negedge Clk);
            k++;
        end
        chk("reach_cruise", {31'd0, e_at}, 32'd1);
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1 chk("async_reset_outputs", {29'd0, bus.Run, bus.Step, bus.AtSpeed}, 32'd0);
        #1 Reset = 1'b0;
        repeat (80) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spin_step_gen.md
Name: spin_step_gen

Overview:
Upstream stage of the disk-spinner display path. Conditions the raw Start pushbutton with synchronisation and debounce, and uses each press to toggle the spinner between stopped and running. While running it produces single-cycle Step pulses with an accelerate/cruise/decelerate speed ramp. The downstream phase counter advances one segment position per Step, and Run gates that counter.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level (>=2)
DIV_W, 16, width of the step divider and period registers
SLOW_DIV, 50000, step period in clocks at start/stop speed (< 2^DIV_W)
FAST_DIV, 12500, step period in clocks at cruise speed (2 <= FAST_DIV <= SLOW_DIV)
RAMP_STEP, 2500, period change applied per Step while ramping (>=1)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  raw pushbutton, asynchronous to Clk, bouncy
Run  output  1  high in every state except IDLE
Step  output  1  one-cycle pulse, advance spinner phase
AtSpeed  output  1  high only in CRUISE

Behaviour:
- Reset (async, active-high) clears: both synchroniser FFs, the debounce counter and the debounced level to 0; divider to 0; period to SLOW_DIV; state to IDLE. Run=0, Step=0, AtSpeed=0. All outputs are registered.
- Input conditioning: Start passes through a 2-FF synchroniser. The debounce counter counts while the sync output differs from the debounced level, and clears when they match. When the count reaches DEB_CYCLES, the debounced level takes the sync value and the counter clears.
- A press is a rising edge of the debounced level. It is one internal cycle wide. A debounced falling edge has no effect.
- Press latency: Run rises exactly DEB_CYCLES+3 clocks after the first Clk edge that samples Start high, provided Start stays high that long. Glitches shorter than DEB_CYCLES clocks after sync are ignored.
- Divider: runs in every state except IDLE, counting 0..period-1. Step=1 in the cycle after the divider equals period-1, and the divider wraps to 0 at that point. Entering ACCEL from IDLE clears the divider, so the first Step comes SLOW_DIV clocks after Run rises.
- State machine (IDLE, ACCEL, CRUISE, DECEL):
  IDLE: press -> ACCEL, period=SLOW_DIV.
  ACCEL: at each step, period = max(period-RAMP_STEP, FAST_DIV). If the new period == FAST_DIV -> CRUISE. Press -> DECEL.
  CRUISE: period holds FAST_DIV. Press -> DECEL.
  DECEL: at each step, if period+RAMP_STEP >= SLOW_DIV -> IDLE (period=SLOW_DIV, no further Step). Otherwise period += RAMP_STEP. Press -> ACCEL.
- Arithmetic: compute period math at DIV_W+1 bits so it cannot wrap. Results saturate at FAST_DIV and SLOW_DIV.
- Press and step in the same cycle: the step's period update uses the pre-press state, and the press transition is applied to the state in the same cycle. Exceptions:
  - DECEL step reaching IDLE wins over a simultaneous press; the press is dropped.
  - ACCEL step reaching CRUISE coinciding with a press -> DECEL.
- A period change takes effect from the next divider cycle only. A step period in progress is never shortened or lengthened.
- Start held high indefinitely produces only one press. Reset mid-ramp returns to IDLE immediately with no Step.

Test Plan:
(Benches use DEB_CYCLES=4, SLOW_DIV=20, FAST_DIV=8, RAMP_STEP=4.)
- Reset then idle: Start=0 for 200 clks -> Run=0, Step never asserted, AtSpeed=0.
- Clean press, Start 0->1 held: Run rises 7 clks after first sampled high. Step gaps are 20,16,12,8,8,... AtSpeed rises with the state change at the 3rd Step.
- Bounce rejection: Start toggles every 2 clks for 30 clks, then settles high -> exactly one press, one ACCEL entry. Pulses of 3 clks alone -> no press.
- Stop from CRUISE: press while AtSpeed=1 -> AtSpeed falls. The current 8-clk period completes, then gaps are 12 and 16, then Run falls at the 3rd decel Step with no further Step.
- Reversal: press during ACCEL after the 1st Step -> DECEL. Press during DECEL -> ACCEL. Periods never go outside [8,20].
- Async reset mid-CRUISE: Reset pulsed off-edge -> Run, Step, AtSpeed go 0 immediately. After release, a press gives a first Step 20 clks after Run rises.
